ship_collision_monitor: RTL
===========================

Name: ship_collision_monitor

Overview:
- Sits directly downstream of the spaceship and asteroid_generator stages. It drives the spaceship `collision` input, which is currently tied to 0.
- Each scan checks the ship position against every active asteroid, one asteroid per cycle, using a bounding-box test.
- On a hit it issues a one-cycle collision pulse, decrements lives, opens an invulnerability window, and asserts gameover when lives reach 0.

Parameters:
- NUM_AST, 8: number of asteroid slots; the coordinate buses are packed, slot i in the i-th field.
- X_W, 8: x coordinate width.
- Y_W, 7: y coordinate width.
- HIT_RADIUS, 4: half-size of the hit box in pixels; a hit requires both |dx| <= HIT_RADIUS and |dy| <= HIT_RADIUS.
- INVULN_TICKS, 100000000: invulnerability window in clk cycles (2 s at 50 MHz).
- START_LIVES, 3: lives loaded on start; legal range 1..3.

Ports:
- clk  in  1  system clock, CLOCK_50.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a game, or restarts one, from any state.
- ship_x  in  X_W  ship x position.
- ship_y  in  Y_W  ship y position.
- ast_x  in  NUM_AST*X_W  packed asteroid x coordinates.
- ast_y  in  NUM_AST*Y_W  packed asteroid y coordinates.
- ast_active  in  NUM_AST  asteroid slot valid (moving) flags.
- collision  out  1  one-cycle pulse on a ship hit; feeds spaceship.collision.
- hit_mask  out  NUM_AST  asteroids involved in the last hit; held until the next hit or start.
- lives  out  2  remaining lives.
- invulnerable  out  1  high while the invulnerability window runs.
- gameover  out  1  high in OVER.
- scan_done  out  1  one-cycle pulse when a scan completes with no hit.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, idx=0, timer=0.
  - lives=START_LIVES.
  - collision=0, hit_mask=0, invulnerable=0, gameover=0, scan_done=0.
  - The internal hit accumulator is cleared.
- States: IDLE, SCAN, HIT, INVULN, OVER.
- IDLE: all outputs held. start -> SCAN with lives=START_LIVES, idx=0, hit_mask=0.
- SCAN:
  - When idx==0, snapshot ship_x/ship_y into registers; the whole scan uses the snapshot.
  - Each cycle, test slot idx using the live ast_x/ast_y/ast_active values and OR the result into accumulator bit idx.
  - Increment idx each cycle.
  - After idx==NUM_AST-1:
    - If the accumulator is non-zero -> HIT.
    - Else pulse scan_done for 1 cycle, clear the accumulator, set idx=0, and stay in SCAN.
  - One scan takes exactly NUM_AST cycles; back-to-back scans have no gap cycle.
- Hit test:
  - The slot must be active.
  - Distances are computed unsigned: abs(a-s) uses X_W+1 / Y_W+1 bit subtraction and takes the magnitude.
  - No screen wrap-around is applied.
  - The comparison is inclusive at exactly HIT_RADIUS.
- HIT (1 cycle):
  - collision=1.
  - hit_mask <= accumulator.
  - lives <= lives-1, saturating at 0.
  - If the new lives value is 0 -> OVER; else -> INVULN with timer=INVULN_TICKS-1.
  - A hit is registered in the cycle after the last slot is tested, so collision fires NUM_AST+1 cycles after the snapshot.
- Multiple asteroids hit in one scan:
  - Only one life is lost.
  - All corresponding hit_mask bits are set.
- INVULN:
  - invulnerable=1; no testing is done.
  - Timer decrements each cycle.
  - At timer==0: invulnerable=0, accumulator cleared, idx=0, -> SCAN.
- OVER: gameover=1; lives=0 is held; only start leaves this state.
- start (any state):
  - Has priority over every other transition in the same cycle, including a pending HIT.
  - -> SCAN, lives=START_LIVES, hit_mask=0, invulnerable=0, gameover=0, timer=0.
  - No collision pulse is produced.
- Outputs collision, scan_done and gameover are registered (no combinational path from the inputs).
- A reset mid-scan or mid-window discards all progress and returns to IDLE.

Decomposition:
- Shared package asteroids_pkg holds:
  - The state encoding (IDLE/SCAN/HIT/INVULN/OVER) as a typedef.
  - NUM_AST, X_W, Y_W.
  - Slot-extract helper functions for the packed coordinate buses, also used by the bullet and graphics blocks.
- One combinational sub-module, box_hit_test: inputs ax, ay, sx, sy, active and radius; output hit.
- The FSM, index counter and timer stay in the top module.

Test Plan:
Bench uses INVULN_TICKS=16.
1. Reset then start; all ast_active=0 -> scan_done pulses every 8 cycles; collision never fires; lives=3.
2. Ship (79,59); slot 3 active at (83,55) -> collision pulses 9 cycles after the snapshot; hit_mask=8'h08; lives=2; invulnerable high for exactly 16 cycles, then scanning resumes.
3. Ship (79,59); slot 3 at (84,59) (dx=5) and slot 5 inactive at (79,59) -> no collision; scan_done keeps pulsing.
4. Slots 0 and 7 both overlapping the ship -> exactly one collision pulse; hit_mask=8'h81; lives drops by exactly 1.
5. Keep an asteroid overlapping the ship through three windows -> lives 3->2->1->0; gameover=1 after the third hit; no further collision pulses; start -> lives=3, gameover=0, scanning resumes.
6. Assert start in the same cycle HIT would occur, and separately drop resetn mid-INVULN -> start: no collision, lives=3; reset: state IDLE, all outputs 0, lives=3 asynchronously.

Source files
------------

// File: rtl/asteroids_pkg.sv
// -----------------------------------------------------------------------------
// asteroids_pkg
// Shared definitions for the asteroid game datapath blocks:
//   - asteroid slot count and screen coordinate widths
//   - game state encoding used by the collision monitor
//   - slot-extract helpers for the packed per-slot coordinate/flag buses,
//     shared with the bullet and graphics blocks
// No ports (package).
// -----------------------------------------------------------------------------
package asteroids_pkg;

    localparam int NUM_AST = 8;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int IDX_W   = (NUM_AST > 1) ? $clog2(NUM_AST) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_HIT    = 3'd2,
        ST_INVULN = 3'd3,
        ST_OVER   = 3'd4
    } game_state_e;

    // Slot i occupies field i of the packed bus, slot 0 in the LSBs.
    function automatic logic [X_W-1:0] slot_x(input logic [NUM_AST*X_W-1:0] bus,
                                              input logic [IDX_W-1:0]       slot);
        return bus[int'(slot)*X_W +: X_W];
    endfunction

    function automatic logic [Y_W-1:0] slot_y(input logic [NUM_AST*Y_W-1:0] bus,
                                              input logic [IDX_W-1:0]       slot);
        return bus[int'(slot)*Y_W +: Y_W];
    endfunction

    function automatic logic slot_flag(input logic [NUM_AST-1:0] flags,
                                       input logic [IDX_W-1:0]   slot);
        return flags[slot];
    endfunction

endpackage

// File: rtl/ship_collision_monitor_box_hit_test.sv
// -----------------------------------------------------------------------------
// box_hit_test
// Combinational bounding-box overlap test between one asteroid and the ship.
// Ports:
//   ax, ay   asteroid position
//   sx, sy   ship position
//   active   asteroid slot valid flag; an inactive slot never hits
//   radius   half-size of the square hit box (inclusive)
//   hit      1 when active and both |ax-sx| and |ay-sy| are <= radius
// -----------------------------------------------------------------------------
module box_hit_test #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int R_W = 8
) (
    input  logic [X_W-1:0] ax,
    input  logic [Y_W-1:0] ay,
    input  logic [X_W-1:0] sx,
    input  logic [Y_W-1:0] sy,
    input  logic           active,
    input  logic [R_W-1:0] radius,
    output logic           hit
);

    localparam int XY_W  = ((X_W > Y_W) ? X_W : Y_W) + 1;
    localparam int CMP_W = (XY_W > R_W) ? XY_W : R_W;

    // One extra bit makes the difference exact; no screen wrap is applied,
    // so objects on opposite edges are far apart.
    logic signed [X_W:0] dx;
    logic signed [Y_W:0] dy;
    logic        [X_W:0] dx_mag;
    logic        [Y_W:0] dy_mag;

    always_comb begin
        dx     = $signed({1'b0, ax}) - $signed({1'b0, sx});
        dy     = $signed({1'b0, ay}) - $signed({1'b0, sy});
        dx_mag = dx[X_W] ? $unsigned(-dx) : $unsigned(dx);
        dy_mag = dy[Y_W] ? $unsigned(-dy) : $unsigned(dy);
        hit    = active
              && (CMP_W'(dx_mag) <= CMP_W'(radius))
              && (CMP_W'(dy_mag) <= CMP_W'(radius));
    end

endmodule

// File: rtl/ship_collision_monitor.sv
// -----------------------------------------------------------------------------
// ship_collision_monitor
// Scans the asteroid slots one per cycle against a snapshot of the ship
// position, and on a hit pulses collision, takes a life, and opens an
// invulnerability window; reaching zero lives ends the game.
// Ports:
//   clk, resetn          system clock, asynchronous active-low reset
//   start                begin / restart a game from any state (highest priority)
//   ship_x, ship_y       ship position (snapshotted at the start of each scan)
//   ast_x, ast_y         packed asteroid coordinates, slot i in field i
//   ast_active           per-slot valid flags
//   collision            one-cycle pulse on a ship hit
//   hit_mask             slots involved in the last hit, held until next hit/start
//   lives                remaining lives
//   invulnerable         high during the invulnerability window
//   gameover             high once lives run out
//   scan_done            one-cycle pulse when a scan completes with no hit
// -----------------------------------------------------------------------------
module ship_collision_monitor
    import asteroids_pkg::*;
#(
    parameter int HIT_RADIUS   = 4,
    parameter int INVULN_TICKS = 100000000,
    parameter int START_LIVES  = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [X_W-1:0]         ship_x,
    input  logic [Y_W-1:0]         ship_y,
    input  logic [NUM_AST*X_W-1:0] ast_x,
    input  logic [NUM_AST*Y_W-1:0] ast_y,
    input  logic [NUM_AST-1:0]     ast_active,
    output logic                   collision,
    output logic [NUM_AST-1:0]     hit_mask,
    output logic [1:0]             lives,
    output logic                   invulnerable,
    output logic                   gameover,
    output logic                   scan_done
);

    localparam int               TMR_W      = (INVULN_TICKS > 1) ? $clog2(INVULN_TICKS) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(INVULN_TICKS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_AST - 1);
    localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);

    function automatic logic [1:0] lives_sat_dec(input logic [1:0] l);
        return (l == 2'd0) ? 2'd0 : l - 2'd1;
    endfunction

    game_state_e        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [1:0]         lives_q, lives_d;
    logic [NUM_AST-1:0] acc_q, acc_d;
    logic [NUM_AST-1:0] hit_mask_q, hit_mask_d;
    logic               collision_q, collision_d;
    logic               scan_done_q, scan_done_d;
    logic               invulnerable_q, invulnerable_d;
    logic               gameover_q, gameover_d;
    logic [X_W-1:0]     sx_q, sx_d;
    logic [Y_W-1:0]     sy_q, sy_d;

    // Slot 0 is tested in the same cycle the snapshot is taken, so it sees
    // the live ship position (which is exactly what gets snapshotted).
    logic [X_W-1:0]     cur_sx;
    logic [Y_W-1:0]     cur_sy;
    logic               slot_hit;
    logic [NUM_AST-1:0] acc_upd;
    logic               scan_last;
    logic [1:0]         lives_dec;

    assign cur_sx    = (idx_q == '0) ? ship_x : sx_q;
    assign cur_sy    = (idx_q == '0) ? ship_y : sy_q;
    assign acc_upd   = acc_q | (NUM_AST'(slot_hit) << idx_q);
    assign scan_last = (idx_q == LAST_IDX);
    assign lives_dec = lives_sat_dec(lives_q);

    box_hit_test #(
        .X_W (X_W),
        .Y_W (Y_W),
        .R_W (X_W)
    ) u_box_hit_test (
        .ax     (slot_x(ast_x, idx_q)),
        .ay     (slot_y(ast_y, idx_q)),
        .sx     (cur_sx),
        .sy     (cur_sy),
        .active (slot_flag(ast_active, idx_q)),
        .radius (X_W'(HIT_RADIUS)),
        .hit    (slot_hit)
    );

    // ---- state register ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            timer_q        <= '0;
            lives_q        <= LIVES_INIT;
            acc_q          <= '0;
            hit_mask_q     <= '0;
            collision_q    <= 1'b0;
            scan_done_q    <= 1'b0;
            invulnerable_q <= 1'b0;
            gameover_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            timer_q        <= timer_d;
            lives_q        <= lives_d;
            acc_q          <= acc_d;
            hit_mask_q     <= hit_mask_d;
            collision_q    <= collision_d;
            scan_done_q    <= scan_done_d;
            invulnerable_q <= invulnerable_d;
            gameover_q     <= gameover_d;
        end
    end

    // Ship snapshot is pure data and is only read after being written.
    always_ff @(posedge clk) begin
        sx_q <= sx_d;
        sy_q <= sy_d;
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_SCAN;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_SCAN:   if (scan_last && (acc_upd != '0)) state_d = ST_HIT;
                ST_HIT:    state_d = (lives_dec == 2'd0) ? ST_OVER : ST_INVULN;
                ST_INVULN: if (timer_q == '0) state_d = ST_SCAN;
                ST_OVER:   state_d = ST_OVER;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // ---- datapath / output logic ----
    always_comb begin
        idx_d       = idx_q;
        timer_d     = timer_q;
        lives_d     = lives_q;
        acc_d       = acc_q;
        hit_mask_d  = hit_mask_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        collision_d = 1'b0;
        scan_done_d = 1'b0;

        if (start) begin
            idx_d      = '0;
            timer_d    = '0;
            lives_d    = LIVES_INIT;
            acc_d      = '0;
            hit_mask_d = '0;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    if (idx_q == '0) begin
                        sx_d = ship_x;
                        sy_d = ship_y;
                    end
                    if (scan_last) begin
                        idx_d = '0;
                        if (acc_upd != '0) begin
                            acc_d = acc_upd;
                        end else begin
                            acc_d       = '0;
                            scan_done_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        acc_d = acc_upd;
                    end
                end
                ST_HIT: begin
                    // Any number of slots in one scan costs a single life.
                    collision_d = 1'b1;
                    hit_mask_d  = acc_q;
                    lives_d     = lives_dec;
                    if (lives_dec != 2'd0) timer_d = TMR_LOAD;
                end
                ST_INVULN: begin
                    if (timer_q == '0) begin
                        acc_d = '0;
                        idx_d = '0;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end

        invulnerable_d = (state_d == ST_INVULN);
        gameover_d     = (state_d == ST_OVER);
    end

    assign collision    = collision_q;
    assign hit_mask     = hit_mask_q;
    assign lives        = lives_q;
    assign invulnerable = invulnerable_q;
    assign gameover     = gameover_q;
    assign scan_done    = scan_done_q;

endmodule
